// File: rtl/serial_add_if.sv
// ============================================================================
// serial_add_if : operand/result bundle between an operand source and serial_add
// Revision      : 1.0
// ============================================================================
`default_nettype none

interface serial_add_if #(
  parameter int WIDTH = 8
);
  logic             start;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             busy;
  logic             done;
  logic [WIDTH:0]   out;

  modport master (output start, a, b, input busy, done, out);
  modport slave  (input start, a, b, output busy, done, out);
endinterface

`default_nettype wire

// File: rtl/serial_add.sv
// ============================================================================
// serial_add : bit-serial unsigned adder, LSB first, one bit per clock
// Revision   : 1.0
// ============================================================================
`default_nettype none

module serial_add #(
  parameter int WIDTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  serial_add_if.slave bus
);

  localparam int CW = $clog2(WIDTH + 1);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] SHIFT = 2'd1;
  localparam logic [1:0] DONE  = 2'd2;

  logic [1:0]       r_state;
  logic [1:0]       w_state_next;
  logic [WIDTH-1:0] r_a_sh;
  logic [WIDTH-1:0] r_b_sh;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH:0]   r_out;
  logic [CW-1:0]    r_cnt;
  logic             r_carry;

  logic             w_sum;
  logic             w_carry;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;
  logic             w_busy;
  logic             w_done;

  // single-bit add cell applied to the current LSBs
  assign w_sum   = r_a_sh[0] ^ r_b_sh[0] ^ r_carry;
  assign w_carry = (r_a_sh[0] & r_b_sh[0]) | (r_carry & (r_a_sh[0] ^ r_b_sh[0]));
  assign w_last  = (r_cnt == CW'(WIDTH - 1));

  generate
    if (WIDTH == 1) begin : g_res_single
      assign w_res_next = w_sum;
    end else begin : g_res_multi
      assign w_res_next = {w_sum, r_res[WIDTH-1:1]};
    end
  endgenerate

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (bus.start) w_state_next = SHIFT;
      SHIFT:   if (w_last)    w_state_next = DONE;
      DONE:    w_state_next = IDLE;
      default: w_state_next = IDLE;
    endcase
  end

  always_comb begin
    w_busy = 1'b0;
    w_done = 1'b0;
    case (r_state)
      SHIFT:   w_busy = 1'b1;
      DONE:    w_done = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_a_sh  <= '0;
      r_b_sh  <= '0;
      r_res   <= '0;
      r_out   <= '0;
      r_cnt   <= '0;
      r_carry <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (bus.start) begin
            r_a_sh  <= bus.a;
            r_b_sh  <= bus.b;
            r_carry <= 1'b0;
            r_cnt   <= '0;
          end
        end
        SHIFT: begin
          r_a_sh  <= r_a_sh >> 1;
          r_b_sh  <= r_b_sh >> 1;
          r_carry <= w_carry;
          r_res   <= w_res_next;
          r_cnt   <= r_cnt + CW'(1);
          // result is published on the edge that enters DONE
          if (w_last) r_out <= {w_carry, w_res_next};
        end
        default: ;
      endcase
    end
  end

  assign bus.busy = w_busy;
  assign bus.done = w_done;
  assign bus.out  = r_out;

endmodule

`default_nettype wire
